// File: rtl/cic_pkg.sv
// Shared types for the CIC decimator control slice: FSM states and the rate/phase type.
package cic_pkg;

  localparam int RateWidthBitsDefault = 8;

  typedef logic [RateWidthBitsDefault-1:0] rate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/cic_decimation_controller_if.sv
// Control/handshake bundle between the CIC sequencer and its environment.
// Handshakes: a transfer happens in a cycle where valid & ready are both high;
// valid must hold until that cycle, and ready may depend on valid combinationally.
interface cic_decimation_controller_if
  import cic_pkg::*;
#(
  parameter int RateWidthBits = RateWidthBitsDefault
) ();

  logic                     enable;
  logic [RateWidthBits-1:0] cfg_rate;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic                     cfg_err;
  logic                     in_valid;
  logic                     in_ready;
  logic                     integ_step;
  logic                     integ_clear;
  logic                     dec_load;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [RateWidthBits-1:0] phase;
  logic                     busy;
  ctrl_state_e              state_dbg;

  // Controller side.
  modport slave (
    input  enable, cfg_rate, cfg_valid, in_valid, dec_ready,
    output cfg_ready, cfg_err, in_ready, integ_step, integ_clear,
           dec_load, dec_valid, phase, busy, state_dbg
  );

  // Environment side: upstream source, config master, comb chain.
  modport master (
    output enable, cfg_rate, cfg_valid, in_valid, dec_ready,
    input  cfg_ready, cfg_err, in_ready, integ_step, integ_clear,
           dec_load, dec_valid, phase, busy, state_dbg
  );

endinterface

// File: rtl/cic_phase_counter.sv
// Modulo-R sample counter: clears to zero, steps on accepted samples, wraps at R-1.
module cic_phase_counter #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [Width-1:0] modulus,
  output logic [Width-1:0] count,
  output logic             wrap
);

  logic [Width-1:0] count_q;

  // Wrap flags the last sample of a frame; count never reaches modulus.
  assign wrap  = (count_q == (modulus - Width'(1)));
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (step) begin
      count_q <= wrap ? '0 : count_q + Width'(1);
    end
  end

endmodule

// File: rtl/cic_decimation_controller.sv
// Sequencer for a CIC decimator: gates samples into the integrators, strobes the
// decimation snapshot every R-th sample and hands it to the comb chain.
module cic_decimation_controller
  import cic_pkg::*;
#(
  parameter int RateWidthBits = RateWidthBitsDefault,
  parameter int DefaultRate   = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  cic_decimation_controller_if.slave bus
);

  typedef logic [RateWidthBits-1:0] rate_w_t;

  ctrl_state_e state_q;
  rate_w_t     rate_q;
  rate_w_t     phase;
  logic        dec_load_q;
  logic        dec_valid_q;
  logic        integ_clear_q;
  logic        cfg_err_q;
  logic        wrap;
  logic        snap_busy;
  logic        in_ready;
  logic        accept;
  logic        phase_clear;

  // A frame-completing sample must wait while the snapshot cannot take a new value.
  assign snap_busy   = dec_load_q | (dec_valid_q & ~bus.dec_ready);
  assign in_ready    = (state_q == RUN) & bus.enable & ~(wrap & snap_busy);
  assign accept      = bus.in_valid & in_ready;
  assign phase_clear = (state_q == CLEAR);

  cic_phase_counter #(
    .Width (RateWidthBits)
  ) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (phase_clear),
    .step    (accept),
    .modulus (rate_q),
    .count   (phase),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rate_q        <= rate_w_t'(DefaultRate);
      dec_load_q    <= 1'b0;
      dec_valid_q   <= 1'b0;
      integ_clear_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      dec_load_q    <= accept & wrap;
      cfg_err_q     <= 1'b0;
      integ_clear_q <= 1'b0;

      // A load in the consume cycle refills the snapshot, so valid stays up.
      if (dec_load_q) begin
        dec_valid_q <= 1'b1;
      end else if (dec_valid_q && bus.dec_ready) begin
        dec_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.cfg_valid) begin
            if (bus.cfg_rate == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              rate_q <= bus.cfg_rate;
            end
          end
          if (bus.enable) begin
            state_q       <= CLEAR;
            integ_clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= RUN;
        end
        RUN: begin
          if (!bus.enable) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (!(dec_load_q || dec_valid_q)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.integ_step  = accept;
  assign bus.integ_clear = integ_clear_q;
  assign bus.dec_load    = dec_load_q;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.phase       = phase;
  assign bus.busy        = (state_q != IDLE);
  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.state_dbg   = state_q;

  a_valid_held : assert property (@(posedge clk) disable iff (!rst_n)
    (dec_valid_q && !bus.dec_ready) |=> dec_valid_q);

  a_phase_bound : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> (phase < rate_q));

endmodule

// File: doc/cic_decimation_controller.md
Name: cic_decimation_controller

Overview:
- Sequences a CIC decimator datapath: the integrator chain, the decimation snapshot register and the comb chain.
- Gates upstream samples into the integrator chain and counts accepted samples modulo a runtime-configurable rate R.
- Strobes the snapshot register on every R-th sample and runs a valid/ready handshake toward the comb chain.
- Handles backpressure, enable/disable, and rate reconfiguration with a clean integrator clear.

Parameters:
- RateWidthBits, 8, width of the rate and phase fields; R is legal in 1..2^RateWidthBits-1.
- DefaultRate, 4, value of the rate register after reset.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- enable  input  1  run request; level-sensitive.
- cfg_rate  input  RateWidthBits  requested decimation rate R.
- cfg_valid  input  1  cfg_rate valid.
- cfg_ready  output  1  configuration accepted this cycle when cfg_valid is also high.
- cfg_err  output  1  one-cycle pulse when a configuration with rate 0 is rejected.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  controller accepts an upstream sample.
- integ_step  output  1  integrator-chain enable; equals in_valid & in_ready (combinational).
- integ_clear  output  1  integrator-chain synchronous clear.
- dec_load  output  1  snapshot-register load strobe.
- dec_valid  output  1  snapshot holds a decimated sample for the comb chain.
- dec_ready  input  1  comb chain consumes the snapshot.
- phase  output  RateWidthBits  accepted-sample count within the current frame.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge) puts the block in:
  - state IDLE, rate_q = DefaultRate, phase = 0.
  - dec_valid = 0, dec_load = 0, integ_clear = 0, cfg_err = 0.
  - in_ready = 0, busy = 0, cfg_ready = 1.
- Reset mid-operation discards any pending dec_valid and any partial frame.
- States:
  - IDLE:
    - cfg_ready = 1.
    - cfg_valid with cfg_rate != 0 sets rate_q <= cfg_rate.
    - cfg_valid with cfg_rate == 0 leaves rate_q unchanged and pulses cfg_err next cycle.
    - enable high moves to CLEAR.
  - CLEAR: lasts exactly one cycle.
    - integ_clear = 1, phase <= 0, in_ready = 0.
    - Next state is RUN.
  - RUN:
    - in_ready = enable & !(phase == rate_q-1 & (dec_load | (dec_valid & !dec_ready))).
    - On accept: if phase == rate_q-1, then phase <= 0 and dec_load <= 1 (registered, one cycle). Otherwise phase <= phase+1.
    - enable low moves to STOP.
  - STOP:
    - in_ready = 0.
    - Stays in STOP while dec_load | dec_valid; then moves to IDLE.
    - The partial frame is discarded; the next CLEAR clears the integrators.
- cfg_ready = 0 outside IDLE. Rate changes only take effect through IDLE -> CLEAR.
- Snapshot timing:
  - dec_load is high in the cycle after the R-th accept, when the integrator output includes sample R.
  - dec_valid <= 1 at the end of the dec_load cycle.
  - Latency from the R-th accept to dec_valid is 2 cycles.
- dec_valid handshake:
  - Stays high until a cycle with dec_valid & dec_ready; it clears at that edge.
  - If dec_load is high in that same cycle, dec_valid stays 1 (new sample replaces the consumed one).
  - dec_valid never drops without a handshake, except on reset.
- Backpressure: an accept that would complete a frame while the snapshot is occupied is stalled. Non-completing accepts are never stalled.
- R = 1: at most one decimated output per 2 cycles (documented limit).
- phase wraps only at rate_q-1; it never reaches rate_q.
- busy = (state != IDLE).

Decomposition:
- cic_pkg holds:
  - typedef enum ctrl_state_e {IDLE, CLEAR, RUN, STOP}.
  - localparam RateWidthBitsDefault = 8.
  - rate_t typedef (logic [RateWidthBits-1:0]).
- Sub-module: cic_phase_counter, a modulo-R counter with step/clear inputs and a wrap flag. The FSM and handshake logic stay in the top module.

Test Plan:
- Reset held 50 cycles with enable=1, in_valid=1 -> in_ready=0, dec_valid=0, phase=0, busy=0 throughout; release -> one CLEAR cycle with integ_clear=1.
- DefaultRate 4, in_valid=1, dec_ready=1, enable=1 -> phase sequence 0,1,2,3,0; dec_load in the cycle after each 4th accept; dec_valid 2 cycles after; 10 outputs from 40 samples.
- cfg_rate=0 in IDLE -> cfg_err pulse, rate stays 4; cfg_rate=7, then enable -> dec_valid once per 7 accepts; cfg_valid during RUN -> cfg_ready=0 and rate unchanged.
- Rate 3, dec_ready=0 -> after the first output, phase stalls at 2 with in_ready=0; dec_ready pulsed once -> exactly one further sample accepted to complete the frame and a new dec_load.
- Rate 1, in_valid=1, dec_ready=1 -> accepts every other cycle; dec_valid pulses alternate; no sample lost.
- enable dropped at phase 2 with dec_valid pending -> STOP until the handshake completes, then IDLE; re-enable -> CLEAR, phase=0.
